// File: rtl/ram_if.sv
// Avalon-MM slave bus bundle for the ram block: byte address, read/write strobes,
// lane enables, write data, and the stall/return path.
interface ram_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic        waitrequest;
    logic [31:0] readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/ram.sv
// Word RAM with an Avalon-MM slave (async read, clocked byte-lane write) and a level-sensitive
// program-load port. Defining RAM_WAITSTATE_EN adds one wait state to every Avalon access.
module ram #(
    parameter int unsigned MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        RAM_Reset,
    ram_if.slave        bus,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr,
    input  logic [31:0] instruction
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [AW-1:0] idx;
    logic [AW-1:0] pl_idx;
    logic          pl_active;
    logic          waitreq;
    logic          commit;
    logic [31:0]   cur_word;
    logic [31:0]   merged;

    // Two stores per word: clocked Avalon copy and a transparent program-load copy.
    // The word's live value is whichever store was written last, tracked by the
    // toggle pair (they differ once a program load is newer than the last Avalon write).
    logic [31:0]          ff_q  [MEM_WORDS];
    logic [MEM_WORDS-1:0] tog_ff_q;
    logic [31:0]          lat_q [MEM_WORDS];
    logic [MEM_WORDS-1:0] tog_lat_q;

    logic unused_bits;
    assign unused_bits = ^{bus.address[31:AW+2], bus.address[1:0], inst_addr[1:0]};

    assign idx       = bus.address[AW+1:2];
    assign pl_idx    = AW'(inst_addr[7:2]);
    assign pl_active = inst_input & RAM_Reset;

    always_latch begin
        for (int i = 0; i < MEM_WORDS; i++) begin
            if (!RAM_Reset) begin
                lat_q[i]     = '0;
                tog_lat_q[i] = 1'b0;
            end else if (inst_input && (pl_idx == AW'(i))) begin
                lat_q[i]     = instruction;
                tog_lat_q[i] = ~tog_ff_q[i];
            end
        end
    end

    assign cur_word = (tog_lat_q[idx] ^ tog_ff_q[idx]) ? lat_q[idx] : ff_q[idx];

    always_comb begin
        merged = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (bus.byteenable[b]) merged[8*b +: 8] = bus.writedata[8*b +: 8];
        end
    end

    // Reads take priority over writes; a concurrent program load to the same word wins.
    assign commit = bus.write & ~bus.read & ~waitreq & ~(pl_active & (pl_idx == idx));

    always_ff @(posedge clk or negedge RAM_Reset) begin
        if (!RAM_Reset) begin
            for (int i = 0; i < MEM_WORDS; i++) ff_q[i] <= '0;
            tog_ff_q <= '0;
        end else if (commit) begin
            ff_q[idx]     <= merged;
            tog_ff_q[idx] <= tog_lat_q[idx];
        end
    end

`ifdef RAM_WAITSTATE_EN
    typedef enum logic {StIdle, StReady} state_e;

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk or negedge RAM_Reset) begin
        if (!RAM_Reset) state_q <= StIdle;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        waitreq = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.read || bus.write) begin
                    waitreq = RAM_Reset;
                    state_d = StReady;
                end
            end
            StReady: state_d = StIdle;
        endcase
    end
`else
    assign waitreq = 1'b0;
`endif

    assign bus.waitrequest = waitreq;
    assign bus.readdata    = (bus.read && !waitreq && RAM_Reset) ? cur_word : '0;

endmodule

// File: tb/tb_ram.sv
// Randomised scoreboard bench for ram: a word-array reference model predicts read data,
// expected reads are queued at issue time and a negedge monitor pops and compares them.
module tb_ram;
`ifdef RAM_WAITSTATE_EN
    localparam int WS = 1;
`else
    localparam int WS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_input;
    logic [7:0]  inst_addr;
    logic [31:0] instruction;

    always #5 clk = ~clk;

    ram_if bus();

    ram #(.MEM_WORDS(64)) dut (
        .clk        (clk),
        .RAM_Reset  (rst_n),
        .bus        (bus),
        .inst_input (inst_input),
        .inst_addr  (inst_addr),
        .instruction(instruction)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model [64];
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every serviced read against the head of the scoreboard queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.read && !bus.waitrequest) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_read: got %08h, expected no read", bus.readdata);
                end else begin
                    check("read_data", bus.readdata, exp_q.pop_front());
                end
            end else begin
                check("readdata_zero", bus.readdata, 32'h0);
            end
            if (!bus.read && !bus.write) check("idle_wait", {31'b0, bus.waitrequest}, 32'h0);
        end
    end

    task automatic wait_ready(output int stalls);
        stalls = 0;
        @(negedge clk);
        while (bus.waitrequest && stalls < 4) begin
            stalls++;
            @(negedge clk);
        end
        if (bus.waitrequest) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_timeout: waitrequest still 1, expected 0 within 4 cycles");
        end
    endtask

    task automatic do_read_exp(input logic [31:0] addr, input logic [31:0] exp);
        int st;
        bus.address = addr;
        bus.read    = 1'b1;
        bus.write   = 1'b0;
        exp_q.push_back(exp);
        wait_ready(st);
        check("read_latency", st, WS);
        @(posedge clk);
        #1 bus.read = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr);
        do_read_exp(addr, model[addr[7:2]]);
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] be);
        int st;
        bus.address    = addr;
        bus.writedata  = data;
        bus.byteenable = be;
        bus.read       = 1'b0;
        bus.write      = 1'b1;
        wait_ready(st);
        for (int b = 0; b < 4; b++) if (be[b]) model[addr[7:2]][8*b +: 8] = data[8*b +: 8];
        @(posedge clk);
        #1 bus.write = 1'b0;
    endtask

    task automatic do_rw(input logic [31:0] addr, input logic [31:0] data);
        int st;
        bus.address    = addr;
        bus.writedata  = data;
        bus.byteenable = 4'hF;
        bus.read       = 1'b1;
        bus.write      = 1'b1;
        exp_q.push_back(model[addr[7:2]]);
        wait_ready(st);
        @(posedge clk);
        #1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic do_write_pl_same(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [31:0] pval);
        int st;
        bus.address    = addr;
        bus.writedata  = data;
        bus.byteenable = 4'hF;
        bus.write      = 1'b1;
        wait_ready(st);
        inst_addr   = addr[7:0];
        instruction = pval;
        inst_input  = 1'b1;
        model[addr[7:2]] = pval;
        @(posedge clk);
        #1;
        bus.write  = 1'b0;
        inst_input = 1'b0;
    endtask

    task automatic pl_load(input logic [7:0] a, input logic [31:0] d);
        inst_addr   = a;
        instruction = d;
        inst_input  = 1'b1;
        model[a[7:2]] = d;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int          op;

        for (int i = 0; i < 64; i++) model[i] = '0;
        rst_n          = 1'b0;
        inst_input     = 1'b0;
        inst_addr      = '0;
        instruction    = '0;
        bus.address    = 32'h4;
        bus.read       = 1'b1;
        bus.write      = 1'b0;
        bus.writedata  = '0;
        bus.byteenable = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        check("reset_readdata", bus.readdata, 32'h0);
        check("reset_wait", {31'b0, bus.waitrequest}, 32'h0);
        bus.read = 1'b0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;

        // Program load with 1-unit spacing, then read back.
        pl_load(8'h04, 32'h2402A234);
        pl_load(8'h08, 32'h00021203);
        pl_load(8'h0C, 32'h00000008);
        inst_input = 1'b0;
        do_read_exp(32'h04, 32'h2402A234);
        do_read_exp(32'h08, 32'h00021203);
        do_read_exp(32'h0C, 32'h00000008);

        do_write(32'h08, 32'h000000FF, 4'b0001);
        do_read_exp(32'h08, 32'h000212FF);
        do_write(32'h08, 32'hFFFFFFFF, 4'b0000);
        do_read_exp(32'h08, 32'h000212FF);
        do_read_exp(32'hBFC00004, 32'h2402A234);
        do_rw(32'h04, 32'hFFFFFFFF);
        do_read_exp(32'h04, 32'h2402A234);
        do_write_pl_same(32'h10, 32'h11111111, 32'hCAFEF00D);
        do_read_exp(32'h10, 32'hCAFEF00D);

        for (int n = 0; n < 300; n++) begin
            a  = $urandom();
            d  = $urandom();
            op = $urandom_range(0, 9);
            if (op <= 3)      do_read(a);
            else if (op <= 6) do_write(a, d, 4'($urandom_range(0, 15)));
            else if (op == 7) do_rw(a, d);
            else if (op == 8) begin
                pl_load(a[7:0], d);
                inst_input = 1'b0;
                do_read(a);
            end else          do_write_pl_same(a, $urandom(), d);
        end

        // Asynchronous reset between edges with a live read, writes ignored while low.
        bus.address = 32'h04;
        bus.read    = 1'b1;
        #2 rst_n    = 1'b0;
        #1;
        check("midrst_readdata", bus.readdata, 32'h0);
        check("midrst_wait", {31'b0, bus.waitrequest}, 32'h0);
        bus.read       = 1'b0;
        bus.write      = 1'b1;
        bus.writedata  = 32'hA5A5A5A5;
        bus.byteenable = 4'hF;
        pl_load(8'h20, 32'hDEADBEEF);
        inst_input = 1'b0;
        @(posedge clk);
        #1 bus.write = 1'b0;
        for (int i = 0; i < 64; i++) model[i] = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++) do_read_exp(32'(i * 4), 32'h0);

        repeat (2) @(posedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
